// File: rtl/rmt_ingress_filter_pkg.sv
// -----------------------------------------------------------------------------
// rmt_filter_pkg
// Shared constants for the ingress admission filter: protocol values, the
// first-beat byte offsets of the header fields it inspects, and the
// packet-level FSM state type.
// -----------------------------------------------------------------------------
package rmt_filter_pkg;

  localparam logic [15:0] TPID_VLAN   = 16'h8100;
  localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP = 8'h11;

  // Byte offsets within the first beat (byte 0 sits in tdata[7:0]).
  localparam int unsigned OFF_TPID  = 12;
  localparam int unsigned OFF_TCI   = 14;
  localparam int unsigned OFF_ETYPE = 16;
  localparam int unsigned OFF_PROTO = 27;
  localparam int unsigned OFF_DPORT = 40;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } filt_state_t;

  // Multi-byte header fields are big-endian on the wire.
  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rmt_ingress_filter_hdr_check.sv
// -----------------------------------------------------------------------------
// axis_hdr_check
// Purely combinational first-beat classifier.
//   tdata_i/tkeep_i/tlast_i : first beat of a packet
//   drop_o                  : packet must be discarded (bad VLAN/IPv4 header
//                             or a single-beat packet shorter than the minimum)
//   is_ctrl_o               : admitted UDP packet to the control port
// -----------------------------------------------------------------------------
module axis_hdr_check
  import rmt_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter logic [15:0] CTRL_UDP_PORT = 16'hf1f2,
  parameter int unsigned MIN_PKT_BYTES = 64
) (
  input  logic [DATA_WIDTH-1:0]   tdata_i,
  input  logic [DATA_WIDTH/8-1:0] tkeep_i,
  input  logic                    tlast_i,
  output logic                    drop_o,
  output logic                    is_ctrl_o
);

  logic [15:0] tpid;
  logic [15:0] tci;
  logic [15:0] etype;
  logic [7:0]  proto;
  logic [15:0] dport;
  logic        hdr_bad;
  logic        too_short;

  always_comb begin
    tpid  = be16(tdata_i[OFF_TPID*8 +: 8],  tdata_i[(OFF_TPID+1)*8 +: 8]);
    tci   = be16(tdata_i[OFF_TCI*8 +: 8],   tdata_i[(OFF_TCI+1)*8 +: 8]);
    etype = be16(tdata_i[OFF_ETYPE*8 +: 8], tdata_i[(OFF_ETYPE+1)*8 +: 8]);
    proto = tdata_i[OFF_PROTO*8 +: 8];
    dport = be16(tdata_i[OFF_DPORT*8 +: 8], tdata_i[(OFF_DPORT+1)*8 +: 8]);

    hdr_bad   = (tpid != TPID_VLAN) || (tci[11:0] == 12'h000) || (etype != ETYPE_IPV4);
    // Only a packet that ends on its first beat can be short; tkeep is
    // contiguous, so its popcount is the byte count.
    too_short = tlast_i && (32'($countones(tkeep_i)) < MIN_PKT_BYTES);

    drop_o    = hdr_bad || too_short;
    is_ctrl_o = !drop_o && (proto == IPPROTO_UDP) && (dport == CTRL_UDP_PORT);
  end

  // Priority/PCP/DEI bits of the TCI and the payload bytes are not inspected.
  logic unused_ok;
  assign unused_ok = ^{tdata_i, tci[15:12]};

endmodule

// File: rtl/rmt_ingress_filter.sv
// -----------------------------------------------------------------------------
// rmt_ingress_filter
// AXI-Stream admission stage ahead of rmt_wrapper. Forwards VLAN-tagged IPv4
// packets through a single output register slice, discards everything else
// whole, and marks control packets in tuser.
//   clk, aresetn            : clock, synchronous active-low reset
//   s_axis_*                : ingress stream (tready out)
//   m_axis_*                : stream to rmt_wrapper (tready in)
//   pass_cnt/drop_cnt/ctrl_cnt : per-packet counters, wrap on overflow
// -----------------------------------------------------------------------------
module rmt_ingress_filter
  import rmt_filter_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
  parameter int unsigned CTRL_TUSER_BIT       = 127,
  parameter int unsigned MIN_PKT_BYTES        = 64,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [CNT_WIDTH-1:0]              pass_cnt,
  output logic [CNT_WIDTH-1:0]              drop_cnt,
  output logic [CNT_WIDTH-1:0]              ctrl_cnt
);

  localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  filt_state_t state_q, state_d;
  logic        ctrl_q, ctrl_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [KEEP_W-1:0]               tkeep_q, tkeep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                            tvalid_q, tvalid_d;
  logic                            tlast_q, tlast_d;

  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;

  logic hc_drop, hc_ctrl;
  logic first_beat, drop_beat, ctrl_beat, out_free, in_hs, pass_hs;

  axis_hdr_check #(
    .DATA_WIDTH   (C_S_AXIS_DATA_WIDTH),
    .CTRL_UDP_PORT(CTRL_UDP_PORT),
    .MIN_PKT_BYTES(MIN_PKT_BYTES)
  ) u_hdr_check (
    .tdata_i  (s_axis_tdata),
    .tkeep_i  (s_axis_tkeep),
    .tlast_i  (s_axis_tlast),
    .drop_o   (hc_drop),
    .is_ctrl_o(hc_ctrl)
  );

  // Decision is live on the first beat, latched for the rest of the packet.
  always_comb begin
    first_beat    = (state_q == IDLE);
    drop_beat     = first_beat ? hc_drop : (state_q == DROP);
    ctrl_beat     = first_beat ? hc_ctrl : ctrl_q;
    out_free      = m_axis_tready | ~tvalid_q;
    // Dropped beats never touch the output register, so they are always
    // accepted, even while a pass beat is stalled downstream.
    s_axis_tready = ~aresetn | drop_beat | out_free;
    in_hs         = s_axis_tvalid & s_axis_tready;
    pass_hs       = in_hs & ~drop_beat;
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          ctrl_d = hc_ctrl;
          if (!s_axis_tlast) state_d = hc_drop ? DROP : PASS;
        end
      end
      PASS, DROP: begin
        if (in_hs && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (pass_hs) begin
      tdata_d  = s_axis_tdata;
      tkeep_d  = s_axis_tkeep;
      tuser_d  = s_axis_tuser;
      tuser_d[CTRL_TUSER_BIT] = s_axis_tuser[CTRL_TUSER_BIT] | ctrl_beat;
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_comb begin
    pass_d     = pass_q;
    drop_d     = drop_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (in_hs && first_beat) begin
      if (hc_drop) drop_d = drop_q + CNT_WIDTH'(1);
      else         pass_d = pass_q + CNT_WIDTH'(1);
      if (hc_ctrl) ctrl_cnt_d = ctrl_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      ctrl_q     <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      pass_q     <= '0;
      drop_q     <= '0;
      ctrl_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      pass_q     <= pass_d;
      drop_q     <= drop_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pass_cnt      = pass_q;
  assign drop_cnt      = drop_q;
  assign ctrl_cnt      = ctrl_cnt_q;

endmodule

// File: tb/tb_rmt_ingress_filter.sv
module tb_rmt_ingress_filter;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 128;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [CW-1:0] pass_cnt, drop_cnt, ctrl_cnt;

  always #5 clk = ~clk;

  rmt_ingress_filter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .CTRL_UDP_PORT       (16'hf1f2),
    .CTRL_TUSER_BIT      (127),
    .MIN_PKT_BYTES       (64),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .pass_cnt     (pass_cnt),
    .drop_cnt     (drop_cnt),
    .ctrl_cnt     (ctrl_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic [UW-1:0] xuser;
    logic          last;
    bit            drop;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned m_pass = 0, m_drop = 0, m_ctrl = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds one packet from header field values; the admit/control decision
  // comes straight from the field rules, not from the encoded bytes.
  task automatic add_pkt(input logic [15:0] tpid, input logic [15:0] tci,
                         input logic [15:0] etype, input logic [7:0] proto,
                         input logic [15:0] dport, input int unsigned nbeats,
                         input int unsigned last_bytes);
    logic [7:0] b [64];
    bit drop, ctrl;
    beat_t bt;
    drop = (tpid != 16'h8100) || (tci[11:0] == 12'h000) || (etype != 16'h0800) ||
           (nbeats == 1 && last_bytes < 64);
    ctrl = !drop && proto == 8'h11 && dport == 16'hf1f2;
    if (drop) m_drop++; else m_pass++;
    if (ctrl) m_ctrl++;
    for (int i = 0; i < int'(nbeats); i++) begin
      for (int j = 0; j < 64; j++) b[j] = 8'($urandom);
      if (i == 0) begin
        b[12] = tpid[15:8];  b[13] = tpid[7:0];
        b[14] = tci[15:8];   b[15] = tci[7:0];
        b[16] = etype[15:8]; b[17] = etype[7:0];
        b[27] = proto;
        b[40] = dport[15:8]; b[41] = dport[7:0];
      end
      for (int j = 0; j < 64; j++) bt.data[j*8 +: 8] = b[j];
      bt.last = (i == int'(nbeats) - 1);
      for (int j = 0; j < KW; j++) bt.keep[j] = !bt.last || (j < int'(last_bytes));
      bt.user  = {$urandom, $urandom, $urandom, $urandom};
      bt.xuser = bt.user;
      if (ctrl) bt.xuser[127] = 1'b1;
      bt.drop  = drop;
      in_q.push_back(bt);
      if (!drop) exp_q.push_back(bt);
    end
  endtask

  task automatic drive(input beat_t bt, input logic v);
    s_tdata  = bt.data;
    s_tkeep  = bt.keep;
    s_tuser  = bt.user;
    s_tlast  = bt.last;
    s_tvalid = v;
  endtask

  // rmode: 0 = tready held high, 1 = toggling, 2 = random.
  task automatic run(input int unsigned rmode, input int unsigned vprob);
    int unsigned budget = 0;
    logic snap_v, snap_r, snap_l, s_hs, m_hs;
    logic [DW-1:0] snap_d;
    logic [UW-1:0] snap_u;
    logic [KW-1:0] snap_k;
    beat_t cur, e;
    while ((in_q.size() != 0 || exp_q.size() != 0) && budget < 3000) begin
      budget++;
      if (in_q.size() != 0) begin
        cur = in_q[0];
        drive(cur, $urandom_range(99) < vprob);
      end else begin
        s_tvalid = 1'b0;
      end
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(1));
      endcase
      #4;
      s_hs   = s_tvalid & s_tready;
      m_hs   = m_tvalid & m_tready;
      snap_v = m_tvalid; snap_r = m_tready; snap_l = m_tlast;
      snap_d = m_tdata;  snap_u = m_tuser;  snap_k = m_tkeep;
      if (s_tvalid && cur.drop) chk("drop_tready", s_tready, 1);
      @(posedge clk); #1;
      if (m_hs) begin
        if (exp_q.size() == 0) chk("spurious_beat_valid", snap_v, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", snap_d, e.data);
          chk("out_keep", snap_k, e.keep);
          chk("out_user", snap_u, e.xuser);
          chk("out_last", snap_l, e.last);
        end
      end
      if (snap_v && !snap_r) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, snap_d);
        chk("hold_user", m_tuser, snap_u);
        chk("hold_last", m_tlast, snap_l);
      end
      if (s_hs) begin
        if (!cur.drop) begin
          chk("lat_valid", m_tvalid, 1);
          chk("lat_data", m_tdata, cur.data);
          chk("lat_user", m_tuser, cur.xuser);
          chk("lat_last", m_tlast, cur.last);
        end
        void'(in_q.pop_front());
      end
    end
    s_tvalid = 1'b0;
    if (budget >= 3000) chk("timeout_pending", in_q.size() + exp_q.size(), 0);
    chk("drained_valid", m_tvalid, 0);
  endtask

  task automatic check_counters();
    chk("pass_cnt", pass_cnt, m_pass);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("ctrl_cnt", ctrl_cnt, m_ctrl);
  endtask

  task automatic rand_pkt();
    logic [15:0] tpid, tci, etype, dport;
    logic [7:0]  proto;
    int unsigned nb, lb;
    tpid  = ($urandom_range(9) == 0) ? 16'($urandom) : 16'h8100;
    tci   = 16'($urandom);
    if ($urandom_range(9) == 0) tci[11:0] = 12'h000;
    etype = ($urandom_range(9) == 0) ? 16'($urandom) : 16'h0800;
    proto = ($urandom_range(1) == 1) ? 8'h11 : 8'($urandom);
    dport = ($urandom_range(1) == 1) ? 16'hf1f2 : 16'($urandom);
    nb    = $urandom_range(1, 4);
    lb    = ($urandom_range(1) == 1) ? 64 : $urandom_range(1, 64);
    add_pkt(tpid, tci, etype, proto, dport, nb, lb);
  endtask

  initial begin
    beat_t b0, b1;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tready", s_tready, 1);
    check_counters();
    aresetn = 1'b1;

    // Plain UDP packet, VID 0x00f.
    add_pkt(16'h8100, 16'h000f, 16'h0800, 8'h11, 16'h1234, 2, 64);
    run(0, 100);
    check_counters();

    // Same packet aimed at the control port.
    add_pkt(16'h8100, 16'h000f, 16'h0800, 8'h11, 16'hf1f2, 2, 64);
    run(0, 100);
    check_counters();

    // Untagged 3-beat packet.
    add_pkt(16'h0800, 16'h000f, 16'h0800, 8'h11, 16'h1234, 3, 64);
    run(0, 100);
    check_counters();

    // Single 32-byte beat.
    add_pkt(16'h8100, 16'h000f, 16'h0800, 8'h11, 16'h1234, 1, 32);
    run(0, 100);
    check_counters();

    // Exactly minimum-size single beat is admitted; VID 0 is dropped.
    add_pkt(16'h8100, 16'h0abc, 16'h0800, 8'h06, 16'h0050, 1, 64);
    add_pkt(16'h8100, 16'hf000, 16'h0800, 8'h11, 16'hf1f2, 2, 10);
    run(0, 100);
    check_counters();

    // Drop followed back-to-back by pass under a toggling tready.
    add_pkt(16'h8100, 16'h0005, 16'h86dd, 8'h11, 16'h1234, 3, 20);
    add_pkt(16'h8100, 16'h0005, 16'h0800, 8'h11, 16'h1234, 4, 17);
    run(1, 100);
    check_counters();

    // Reset during beat 2 of a 3-beat pass packet.
    add_pkt(16'h8100, 16'h0123, 16'h0800, 8'h06, 16'h0000, 3, 40);
    b0 = in_q[0];
    b1 = in_q[1];
    m_tready = 1'b1;
    drive(b0, 1'b1);
    @(posedge clk); #1;
    drive(b1, 1'b1);
    aresetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_tuser", m_tuser, 0);
    chk("mid_rst_tready", s_tready, 1);
    m_pass = 0; m_drop = 0; m_ctrl = 0;
    check_counters();
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    in_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    add_pkt(16'h8100, 16'h0321, 16'h0800, 8'h11, 16'h4321, 2, 33);
    run(0, 100);
    check_counters();

    // Randomized traffic.
    repeat (40) rand_pkt();
    run(2, 70);
    check_counters();
    repeat (30) rand_pkt();
    run(1, 100);
    check_counters();
    repeat (30) rand_pkt();
    run(0, 100);
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
